// File: rtl/vpi_mbox_pkg.sv
// ---------------------------------------------------------------------------
// vpi_mbox_pkg
// Shared types and constants for the VPI mailbox register file: command
// opcodes, target selectors, FSM states, the whole-variable index code and
// the reset value of p1. Also provides the element-width truncation helper
// used by both the write path and the checksum.
// ---------------------------------------------------------------------------
package vpi_mbox_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        SEL_P1    = 3'd0,
        SEL_SP1   = 3'd1,
        SEL_P1LE  = 3'd2,
        SEL_P21   = 3'd3,
        SEL_U2    = 3'd4,
        SEL_P1U1  = 3'd5,
        SEL_P0U12 = 3'd6,
        SEL_RSVD  = 3'd7
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CLR  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [2:0] IDX_WHOLE = 3'd7;
    localparam logic [1:0] P1_RESET  = 2'b10;

    // Keep only the low 'w' bits of a 6-bit value (w is 1, 2 or 6).
    function automatic logic [5:0] trunc_elem(input logic [5:0] v, input logic [2:0] w);
        case (w)
            3'd1:    return {5'b00000, v[0]};
            3'd2:    return {4'b0000, v[1:0]};
            3'd6:    return v;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/vpi_mbox_decode.sv
// ---------------------------------------------------------------------------
// vpi_mbox_decode
// Combinational access decoder for the mailbox.
//   op, sel, idx : latched command fields
//   legal        : access is allowed (NOP/CLEAR are always legal)
//   elem_w       : width in bits of the addressed element (1, 2 or 6)
//   elem_i       : outer index (only meaningful for p0u12)
//   elem_j       : inner / element index
// ---------------------------------------------------------------------------
module vpi_mbox_decode
    import vpi_mbox_pkg::*;
(
    input  op_e        op,
    input  sel_e       sel,
    input  logic [2:0] idx,
    output logic       legal,
    output logic [2:0] elem_w,
    output logic       elem_i,
    output logic [1:0] elem_j
);

    logic       acc_legal_s;
    logic [2:0] idx_m3_s;

    // Per-target index legality, element width and flattened i/j split.
    always_comb begin
        acc_legal_s = 1'b0;
        elem_w      = 3'd0;
        elem_i      = 1'b0;
        elem_j      = idx[1:0];
        idx_m3_s    = idx - 3'd3;
        case (sel)
            SEL_P1, SEL_SP1, SEL_P1LE: begin
                acc_legal_s = (idx == 3'd0);
                elem_w      = 3'd2;
            end
            SEL_P21: begin
                if (idx == IDX_WHOLE) begin
                    acc_legal_s = 1'b1;
                    elem_w      = 3'd6;
                end else begin
                    acc_legal_s = (idx <= 3'd2);
                    elem_w      = 3'd2;
                end
            end
            SEL_U2: begin
                acc_legal_s = (idx <= 3'd2);
                elem_w      = 3'd1;
            end
            SEL_P1U1: begin
                acc_legal_s = (idx <= 3'd1);
                elem_w      = 3'd2;
            end
            SEL_P0U12: begin
                acc_legal_s = (idx <= 3'd5);
                elem_w      = 3'd1;
                if (idx >= 3'd6) begin
                    elem_i = 1'b0;
                    elem_j = 2'd0;
                end else if (idx >= 3'd3) begin
                    elem_i = 1'b1;
                    elem_j = idx_m3_s[1:0];
                end else begin
                    elem_i = 1'b0;
                    elem_j = idx[1:0];
                end
            end
            default: begin
                acc_legal_s = 1'b0;
                elem_w      = 3'd0;
            end
        endcase
        // Only data accesses can be illegal.
        if ((op == OP_WRITE) || (op == OP_READ)) begin
            legal = acc_legal_s;
        end else begin
            legal = 1'b1;
        end
    end

endmodule

// File: rtl/vpi_mbox_regfile.sv
// ---------------------------------------------------------------------------
// vpi_mbox_regfile
// Command/response mailbox applying harness commands to mixed-shape storage.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_op/sel/idx    : opcode, target selector, element index
//   cmd_data          : write data
//   rsp_valid/ready   : response handshake
//   rsp_data, rsp_err : response value and illegal-access flag
//   checksum          : running sum of truncated write values
//   busy              : FSM is not IDLE
// ---------------------------------------------------------------------------
module vpi_mbox_regfile
    import vpi_mbox_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CSUM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_sel,
    input  logic [2:0]        cmd_idx,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CSUM_W-1:0] checksum,
    output logic              busy
);

    state_e state_r, next_state_s;
    logic [2:0] clr_cnt_r;
    op_e        op_r;
    sel_e       sel_r;
    logic [2:0] idx_r;
    logic [5:0] data_r;

    logic              cmd_ready_r, busy_r, rsp_valid_r, rsp_err_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [CSUM_W-1:0] checksum_r;

    // Mixed-shape storage targets.
    logic [1:0]        p1_r;
    logic signed [1:0] sp1_r;
    logic [0:1]        p1le_r;
    logic [2:0][1:0]   p21_r;
    logic              u2_r [2:0];
    logic [1:0]        p1u1_r [1:0];
    logic              p0u12_r [1:0][2:0];

    logic              legal_s, elem_i_s, accept_s, do_write_s, clr_last_s;
    logic [2:0]        elem_w_s;
    logic [1:0]        elem_j_s;
    logic [5:0]        wr_val_s;
    logic [DATA_W-1:0] rd_val_s;

    vpi_mbox_decode u_decode (
        .op     (op_r),
        .sel    (sel_r),
        .idx    (idx_r),
        .legal  (legal_s),
        .elem_w (elem_w_s),
        .elem_i (elem_i_s),
        .elem_j (elem_j_s)
    );

    assign accept_s   = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
    assign do_write_s = (state_r == ST_EXEC) && (op_r == OP_WRITE) && legal_s;
    assign clr_last_s = (state_r == ST_CLR) && (clr_cnt_r == 3'd6);
    assign wr_val_s   = trunc_elem(data_r, elem_w_s);

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign checksum  = checksum_r;

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op_e'(cmd_op) == OP_CLEAR) begin
                        next_state_s = ST_CLR;
                    end else begin
                        next_state_s = ST_EXEC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_RESP;
            ST_CLR: begin
                if (clr_cnt_r == 3'd6) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_CLR;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register, clear counter, status outputs and command latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= 3'd0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            op_r        <= OP_NOP;
            sel_r       <= SEL_P1;
            idx_r       <= 3'd0;
            data_r      <= 6'd0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s != ST_IDLE);
            clr_cnt_r   <= (state_r == ST_CLR) ? clr_cnt_r + 3'd1 : 3'd0;
            if (accept_s) begin
                op_r   <= op_e'(cmd_op);
                sel_r  <= sel_e'(cmd_sel);
                idx_r  <= cmd_idx;
                data_r <= cmd_data[5:0];
            end
        end
    end

    // Read mux: zero-extend everything except sp1, which sign-extends.
    always_comb begin
        rd_val_s = '0;
        case (sel_r)
            SEL_P1:   rd_val_s = DATA_W'(p1_r);
            SEL_SP1:  rd_val_s = DATA_W'(sp1_r);
            SEL_P1LE: rd_val_s = DATA_W'(p1le_r);
            SEL_P21: begin
                if (idx_r == IDX_WHOLE) begin
                    rd_val_s = DATA_W'(p21_r);
                end else begin
                    rd_val_s = DATA_W'(p21_r[elem_j_s]);
                end
            end
            SEL_U2:    rd_val_s = DATA_W'(u2_r[elem_j_s]);
            SEL_P1U1:  rd_val_s = DATA_W'(p1u1_r[elem_j_s[0]]);
            SEL_P0U12: rd_val_s = DATA_W'(p0u12_r[elem_i_s][elem_j_s]);
            default:   rd_val_s = '0;
        endcase
    end

    // Response registers: loaded on EXEC / last CLR, held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r <= 1'b1;
            if (!legal_s) begin
                rsp_data_r <= '0;
                rsp_err_r  <= 1'b1;
            end else if (op_r == OP_WRITE) begin
                rsp_data_r <= DATA_W'(wr_val_s);
                rsp_err_r  <= 1'b0;
            end else if (op_r == OP_READ) begin
                rsp_data_r <= rd_val_s;
                rsp_err_r  <= 1'b0;
            end else begin
                rsp_data_r <= '0;
                rsp_err_r  <= 1'b0;
            end
        end else if (clr_last_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Running checksum of truncated write values; zeroed by CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= '0;
        end else if (clr_last_s) begin
            checksum_r <= '0;
        end else if (do_write_s) begin
            checksum_r <= checksum_r + CSUM_W'(wr_val_s);
        end else begin
            checksum_r <= checksum_r;
        end
    end

    // Storage: reset values, legal writes, and one-target-per-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_r   <= P1_RESET;
            sp1_r  <= 2'sb00;
            p1le_r <= 2'b00;
            p21_r  <= 6'd0;
            for (int k = 0; k < 3; k++) u2_r[k] <= 1'b0;
            for (int k = 0; k < 2; k++) p1u1_r[k] <= 2'b00;
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 3; b++) p0u12_r[a][b] <= 1'b0;
        end else if (do_write_s) begin
            case (sel_r)
                SEL_P1:   p1_r   <= wr_val_s[1:0];
                SEL_SP1:  sp1_r  <= wr_val_s[1:0];
                SEL_P1LE: p1le_r <= wr_val_s[1:0];
                SEL_P21: begin
                    if (idx_r == IDX_WHOLE) begin
                        p21_r <= wr_val_s;
                    end else begin
                        p21_r[elem_j_s] <= wr_val_s[1:0];
                    end
                end
                SEL_U2:    u2_r[elem_j_s] <= wr_val_s[0];
                SEL_P1U1:  p1u1_r[elem_j_s[0]] <= wr_val_s[1:0];
                SEL_P0U12: p0u12_r[elem_i_s][elem_j_s] <= wr_val_s[0];
                default: ;
            endcase
        end else if (state_r == ST_CLR) begin
            case (clr_cnt_r)
                3'd0: p1_r   <= 2'b00;
                3'd1: sp1_r  <= 2'sb00;
                3'd2: p1le_r <= 2'b00;
                3'd3: p21_r  <= 6'd0;
                3'd4: for (int k = 0; k < 3; k++) u2_r[k] <= 1'b0;
                3'd5: for (int k = 0; k < 2; k++) p1u1_r[k] <= 2'b00;
                3'd6: begin
                    for (int a = 0; a < 2; a++)
                        for (int b = 0; b < 3; b++) p0u12_r[a][b] <= 1'b0;
                end
                default: ;
            endcase
        end else begin
            p1_r <= p1_r;
        end
    end

endmodule

// File: doc/vpi_mbox_regfile.md
Name: vpi_mbox_regfile

Overview:
- Command/response mailbox register file that sits directly downstream of the VPI/DPI-driven test harness.
- The C side drives a command (op, target, index, data) into a public_flat_rw-visible request interface. This block applies it to a set of mixed-shape storage variables: packed, little-endian packed, signed, multi-dim packed and unpacked.
- It returns a response and a running checksum, so that VPI writes can be checked against RTL-side sequential effects.

Parameters:
- DATA_W, 6, width of cmd_data/rsp_data; must be >= 6, the widest target.
- CSUM_W, 8, width of the running checksum (modulo 2^CSUM_W).

Ports:
- clk  input  1  clock; all logic is on the posedge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (IDLE only)
- cmd_op  input  2  0 NOP, 1 WRITE, 2 READ, 3 CLEAR
- cmd_sel  input  3  target: 0 p1[1:0], 1 sp1 signed[1:0], 2 p1le[0:1], 3 p21[2:0][1:0], 4 u2[2:0] (1b each), 5 p1u1[1:0] (2b each), 6 p0u12[1:0][2:0] (1b each), 7 reserved
- cmd_idx  input  3  element index; 7 = whole variable (sel 3 only)
- cmd_data  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_data  output  DATA_W  read data, or written value after truncation
- rsp_err  output  1  illegal sel/idx/op
- checksum  output  CSUM_W  running sum of truncated write values
- busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0; checksum=0; busy=0. All storage is 0 except p1=2'b10. Reset mid-operation aborts and discards any pending response.
- FSM states IDLE, EXEC, CLR, RESP.
- IDLE: accept on cmd_valid&&cmd_ready at cycle N and latch the command.
  - NOP/WRITE/READ -> EXEC at N+1.
  - CLEAR -> CLR.
- EXEC: decode legality and perform the access; -> RESP. rsp_valid is first high at N+2.
- CLR: zero one target per cycle, sel 0..6 in order; 7 cycles; then -> RESP. p1 is cleared to 0, not 2'b10. checksum is zeroed on the final CLR cycle. CLEAR rsp_data=0.
- RESP: rsp_valid=1 and rsp_data/rsp_err are held stable until rsp_ready. On the rsp_valid&&rsp_ready cycle -> IDLE, and cmd_ready=1 on the next cycle. There is no back-to-back accept in the same cycle as the response handshake.
- Legal idx per sel:
  - sel 0/1/2: idx 0 only.
  - sel 3: idx 0-2, or 7 for whole 6 bits.
  - sel 4: idx 0-2.
  - sel 5: idx 0-1.
  - sel 6: idx 0-5, with i=idx/3, j=idx%3.
  - sel 7: always illegal.
- Illegal access: no storage change, no checksum change, rsp_err=1, rsp_data=0.
- WRITE: the value is truncated to the element width; truncation is not an error. checksum += zero-extended truncated value, mod 2^CSUM_W. rsp_data = truncated value, zero-extended.
- p1le: stores the numeric value unchanged (cmd_data[0] lands in element [1]); reads return the same numeric value.
- READ: zero-extended, except sp1, which is sign-extended (stored 2'b10 reads as 6'b111110).
- NOP: rsp_data=0, rsp_err=0.
- cmd_valid while not ready is ignored; the source holds it.

Decomposition:
- Package vpi_mbox_pkg:
  - op_e enum (NOP/WRITE/READ/CLEAR)
  - sel_e enum (7 targets + RSVD)
  - state_e enum
  - IDX_WHOLE=3'd7
  - P1_RESET=2'b10
- Sub-module vpi_mbox_decode (combinational): sel/idx/op -> legal flag, element width, flattened i/j.
- The FSM and storage stay in vpi_mbox_regfile.

Test Plan:
- Reset, then READ sel0 idx0 -> rsp_valid at accept+2, rsp_data=6'd2, rsp_err=0, checksum=0.
- WRITE sel1 idx0 data=6'h3E, then READ sel1 -> write rsp_data=2; read rsp_data=6'h3E (sign-extended); checksum=2.
- WRITE sel3 idx7 data=6'h2D, then READ sel3 idx1 -> read rsp_data=3; checksum +=45.
- WRITE sel6 idx6 -> rsp_err=1, storage and checksum unchanged. WRITE sel7 idx0 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid/rsp_data stable, cmd_ready=0. A cmd_valid pulse during the stall is ignored.
- Fill all targets, then CLEAR -> busy for 7 CLR cycles; all reads afterwards return 0 (p1=0); checksum=0. Asserting rst during CLR cycle 3 -> next cycle IDLE, rsp_valid=0, p1=2.
